// File: rtl/hazard_pkg.sv
// Shared constants and types for the hazard/forwarding unit: operand mux
// selects, stall FSM states and counter widths.
package hazard_pkg;
   localparam logic [1:0] FWD_RF    = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b10;
   localparam logic [1:0] FWD_MEMWB = 2'b01;

   localparam int CNT_W       = 4;
   localparam int STALL_CNT_W = 16;

   typedef enum logic {IDLE, STALL} hz_state_e;
endpackage

// File: rtl/hazard_forward_unit_fwd_select.sv
// Per-operand forwarding select: EX/MEM beats MEM/WB, register 0 optionally
// never forwarded. Purely combinational.
module fwd_select
   import hazard_pkg::*;
#(
   parameter int REG_AW   = 3,
   parameter int ZERO_REG = 1
) (
   input  logic [REG_AW-1:0] rs,
   input  logic              ex_mem_regwrite,
   input  logic              ex_mem_is_load,
   input  logic [REG_AW-1:0] ex_mem_rd,
   input  logic              mem_wb_regwrite,
   input  logic [REG_AW-1:0] mem_wb_rd,
   output logic [1:0]        sel
);
   logic rs_ok;

   always_comb begin
      rs_ok = (ZERO_REG == 0) || (rs != '0);
      sel   = FWD_RF;
      // A load in EX/MEM has no data yet; it can only be picked up from MEM/WB.
      if (rs_ok && ex_mem_regwrite && !ex_mem_is_load && (ex_mem_rd == rs))
         sel = FWD_EXMEM;
      else if (rs_ok && mem_wb_regwrite && (mem_wb_rd == rs))
         sel = FWD_MEMWB;
   end
endmodule

// File: rtl/hazard_forward_unit.sv
// RAW forwarding for NUM_SRC EX operands plus load-use detection with a
// LOAD_LAT-cycle stall/bubble sequencer and a saturating stall counter.
module hazard_forward_unit
   import hazard_pkg::*;
#(
   parameter int REG_AW   = 3,
   parameter int NUM_SRC  = 2,
   parameter int LOAD_LAT = 1,
   parameter int ZERO_REG = 1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        flush_in,
   input  logic                        id_valid,
   input  logic [NUM_SRC*REG_AW-1:0]   id_rs,
   input  logic [NUM_SRC-1:0]          id_rs_used,
   input  logic                        ex_valid,
   input  logic [NUM_SRC*REG_AW-1:0]   ex_rs,
   input  logic [REG_AW-1:0]           ex_rd,
   input  logic                        ex_regwrite,
   input  logic                        ex_is_load,
   input  logic                        ex_mem_regwrite,
   input  logic                        ex_mem_is_load,
   input  logic [REG_AW-1:0]           ex_mem_rd,
   input  logic                        mem_wb_regwrite,
   input  logic [REG_AW-1:0]           mem_wb_rd,
   output logic [NUM_SRC*2-1:0]        fwd_sel,
   output logic                        stall,
   output logic                        bubble_ex,
   output logic [STALL_CNT_W-1:0]      stall_cycles
);
   logic [NUM_SRC-1:0][REG_AW-1:0] id_rs_a, ex_rs_a;
   logic [NUM_SRC-1:0][1:0]        fwd_sel_a;
   logic [NUM_SRC-1:0]             src_hit;
   logic                           hz, stall_raw;

   hz_state_e                      state_q, state_d;
   logic [CNT_W-1:0]               cnt_q, cnt_d;
   logic [STALL_CNT_W-1:0]         stall_cycles_q, stall_cycles_d;

   assign id_rs_a = id_rs;
   assign ex_rs_a = ex_rs;
   assign fwd_sel = fwd_sel_a;

   for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
      fwd_select #(.REG_AW(REG_AW), .ZERO_REG(ZERO_REG)) u_fwd (
         .rs              (ex_rs_a[g]),
         .ex_mem_regwrite (ex_mem_regwrite),
         .ex_mem_is_load  (ex_mem_is_load),
         .ex_mem_rd       (ex_mem_rd),
         .mem_wb_regwrite (mem_wb_regwrite),
         .mem_wb_rd       (mem_wb_rd),
         .sel             (fwd_sel_a[g])
      );
   end

   always_comb begin
      for (int i = 0; i < NUM_SRC; i++)
         src_hit[i] = id_rs_used[i] && (id_rs_a[i] == ex_rd);
      hz = id_valid && ex_valid && ex_regwrite && ex_is_load && (|src_hit)
           && ((ZERO_REG == 0) || (ex_rd != '0));
   end

   // First stall cycle is spent in IDLE, so STALL covers the remaining LOAD_LAT-1.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      stall_raw = 1'b0;
      if (flush_in) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: if (hz) begin
               stall_raw = 1'b1;
               if (LOAD_LAT > 1) begin
                  state_d = STALL;
                  cnt_d   = CNT_W'(LOAD_LAT - 2);
               end
            end
            STALL: begin
               stall_raw = 1'b1;
               if (cnt_q == '0) state_d = IDLE;
               else             cnt_d   = cnt_q - CNT_W'(1);
            end
            default: state_d = IDLE;
         endcase
      end
      stall_cycles_d = stall_cycles_q;
      if (stall_raw && (stall_cycles_q != '1))
         stall_cycles_d = stall_cycles_q + STALL_CNT_W'(1);
   end

   // Gating with rst_n makes stall drop the instant reset asserts.
   assign stall        = stall_raw && rst_n;
   assign bubble_ex    = stall;
   assign stall_cycles = stall_cycles_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         stall_cycles_q <= '0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         stall_cycles_q <= stall_cycles_d;
      end
   end
endmodule
